// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: PC-source encoding driven by the control unit,
// the canonical NOP word and the fetch-stage state encoding.
package riscv_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JAL = 2'b10,
    PCSRC_RSV = 2'b11
  } pc_src_e;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_VALID = 3'd3,
    FETCH_ERR   = 3'd4
  } fetch_state_e;

  // Reserved encoding falls back to sequential, so only BR and JAL add the immediate.
  function automatic logic pc_src_uses_imm(input logic [1:0] src);
    return (src == PCSRC_BR) || (src == PCSRC_JAL);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC arithmetic for the fetch stage: PC+4 or PC+imm with modulo wrap,
// plus the word-alignment check on the resulting target.
module fetch_next_pc
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] offset;

  always_comb begin
    offset     = pc_src_uses_imm(pc_src) ? imm_ext : XLEN'(4);
    next_pc    = pc + offset;
    misaligned = |next_pc[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the architectural PC, keeps one request in
// flight to instruction memory and presents the fetched word to decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm_ext,
  input  logic            dec_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_err
);

  fetch_state_e    state;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  fetch_next_pc #(
    .XLEN (XLEN)
  ) u_next_pc (
    .pc         (pc),
    .pc_src     (pc_src),
    .imm_ext    (imm_ext),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  // imem_rvalid is only looked at in WAIT, so stale or zero-latency responses drop out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_IDLE;
      pc          <= RESET_PC;
      instr       <= INSTR_NOP;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        FETCH_IDLE: state <= FETCH_REQ;
        FETCH_REQ:  state <= FETCH_WAIT;
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= FETCH_VALID;
          end
        end
        FETCH_VALID: begin
          if (dec_ready) begin
            instr_valid <= 1'b0;
            if (misaligned) begin
              fetch_err <= 1'b1;
              state     <= FETCH_ERR;
            end else begin
              pc    <= next_pc;
              state <= FETCH_REQ;
            end
          end
        end
        FETCH_ERR: begin
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
        end
        default: begin
          instr_valid <= 1'b0;
          state       <= FETCH_IDLE;
        end
      endcase
    end
  end

  assign imem_req  = (state == FETCH_REQ);
  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a latency-varying memory responder and a
// PC-sequencing reference model check fetch order, redirects and error handling.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] imm_ext = 32'h0;
  logic        dec_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_src      (pc_src),
    .imm_ext     (imm_ext),
    .dec_ready   (dec_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  logic [31:0] req_addrs[$];
  int          req_cycles[$];
  bit          mem_auto = 1'b1;
  bit          spur_en = 1'b0;
  int          lat_fixed = 1;
  int          countdown = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] exp_pc = RESET_PC;

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[17:2]};
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [1:0] src,
                                           input logic [31:0] imm);
    if (src == 2'b01 || src == 2'b10) return p + imm;
    return p + 32'd4;
  endfunction

  // Request monitor: samples just after each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (imem_req === 1'b1) begin
      req_addrs.push_back(imem_addr);
      req_cycles.push_back(cyc);
    end
  end

  // Memory responder with optional spurious rvalid pulses outside the wait window.
  initial forever begin
    @(negedge clk);
    if (!mem_auto) begin
      countdown = 0;
    end else begin
      imem_rvalid = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
        end
      end else if (imem_req === 1'b1) begin
        pend_addr = imem_addr;
        countdown = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
        if (spur_en && $urandom_range(0, 1) == 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = $urandom;
        end
      end else if (spur_en && $urandom_range(0, 2) == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic accept(input logic [1:0] src, input logic [31:0] imm);
    pc_src    = src;
    imm_ext   = imm;
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    pc_src    = 2'($urandom);
    imm_ext   = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (pc !== RESET_PC) $display("[TB] FAIL reset_pc: got %h expected %h", pc, RESET_PC); else passed++;
    total++; if (instr !== NOP) $display("[TB] FAIL reset_instr: got %h expected %h", instr, NOP); else passed++;
    total++; if (instr_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); else passed++;
    total++; if (imem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", imem_req); else passed++;
    total++; if (fetch_err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", fetch_err); else passed++;
    total++; if (pc_plus4 !== RESET_PC + 32'd4) $display("[TB] FAIL reset_pc_plus4: got %h expected %h", pc_plus4, RESET_PC + 32'd4); else passed++;
  endtask

  task automatic test_sequential();
    int rel;
    bit ok;
    lat_fixed = 1;
    spur_en   = 1'b0;
    pc_src    = 2'b00;
    dec_ready = 1'b1;
    req_addrs.delete();
    req_cycles.delete();
    rel   = cyc;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (req_addrs.size() >= 3) break;
    end
    dec_ready = 1'b0;
    total++;
    if (req_addrs.size() < 3) begin
      $display("[TB] FAIL seq_req_count: got %0d expected 3", req_addrs.size());
    end else begin
      passed++;
      total++; if ({req_addrs[0], req_addrs[1], req_addrs[2]} !== {32'h0, 32'h4, 32'h8})
        $display("[TB] FAIL seq_addrs: got %h %h %h expected 0 4 8", req_addrs[0], req_addrs[1], req_addrs[2]); else passed++;
      total++; if (req_cycles[0] != rel + 1)
        $display("[TB] FAIL seq_first_req: got cycle %0d expected %0d", req_cycles[0], rel + 1); else passed++;
      total++; if (req_cycles[1] - req_cycles[0] != 3 || req_cycles[2] - req_cycles[1] != 3)
        $display("[TB] FAIL seq_spacing: got %0d %0d expected 3 3", req_cycles[1] - req_cycles[0], req_cycles[2] - req_cycles[1]); else passed++;
    end
    exp_pc = 32'h8;
    wait_valid(ok);
    total++; if (!ok) $display("[TB] FAIL seq_valid_timeout: got no instr_valid expected 1"); else passed++;
    total++; if ({pc, instr, pc_plus4, imem_addr} !== {exp_pc, mem_word(exp_pc), exp_pc + 32'd4, exp_pc})
      $display("[TB] FAIL seq_present: got pc %h instr %h expected pc %h instr %h", pc, instr, exp_pc, mem_word(exp_pc)); else passed++;
  endtask

  task automatic test_branch();
    bit ok;
    int a;
    logic [31:0] got;
    accept(2'b10, 32'h0000_00F8);
    exp_pc = 32'h100;
    wait_valid(ok);
    total++; if (!ok || pc !== exp_pc) $display("[TB] FAIL br_setup_pc: got %h expected %h", pc, exp_pc); else passed++;
    req_addrs.delete();
    req_cycles.delete();
    a = cyc;
    accept(2'b01, 32'hFFFF_FFF8);
    exp_pc = 32'h0F8;
    got = (req_addrs.size() > 0) ? req_addrs[0] : 32'hFFFF_FFFF;
    total++; if (got !== exp_pc) $display("[TB] FAIL br_req_addr: got %h expected %h", got, exp_pc); else passed++;
    total++; if (req_cycles.size() == 0 || req_cycles[0] != a + 1)
      $display("[TB] FAIL br_req_cycle: got %0d expected %0d", (req_cycles.size() > 0) ? req_cycles[0] : -1, a + 1); else passed++;
    wait_valid(ok);
    total++; if (!ok || {pc, instr} !== {exp_pc, mem_word(exp_pc)})
      $display("[TB] FAIL br_present: got pc %h instr %h expected pc %h instr %h", pc, instr, exp_pc, mem_word(exp_pc)); else passed++;
  endtask

  task automatic test_jal();
    bit ok;
    logic [31:0] got;
    accept(2'b01, 32'h20 - 32'hF8);
    exp_pc = 32'h20;
    wait_valid(ok);
    total++; if (!ok || {pc, pc_plus4} !== {32'h20, 32'h24})
      $display("[TB] FAIL jal_pc_plus4: got pc %h pc_plus4 %h expected 20 24", pc, pc_plus4); else passed++;
    req_addrs.delete();
    accept(2'b10, 32'h40);
    exp_pc = 32'h60;
    got = (req_addrs.size() > 0) ? req_addrs[0] : 32'hFFFF_FFFF;
    total++; if (got !== exp_pc) $display("[TB] FAIL jal_req_addr: got %h expected %h", got, exp_pc); else passed++;
    wait_valid(ok);
    total++; if (!ok || {pc, instr} !== {exp_pc, mem_word(exp_pc)})
      $display("[TB] FAIL jal_present: got pc %h instr %h expected pc %h instr %h", pc, instr, exp_pc, mem_word(exp_pc)); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    spur_en   = 1'b1;
    lat_fixed = 0;
    accept(2'b00, $urandom);
    exp_pc = exp_pc + 32'd4;
    wait_valid(ok);
    total++; if (!ok) $display("[TB] FAIL bp_valid_timeout: got no instr_valid expected 1"); else passed++;
    req_addrs.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({instr_valid, pc, instr} !== {1'b1, exp_pc, mem_word(exp_pc)})
        $display("[TB] FAIL bp_hold%0d: got v %b pc %h instr %h expected v 1 pc %h instr %h",
                 i, instr_valid, pc, instr, exp_pc, mem_word(exp_pc)); else passed++;
    end
    total++; if (req_addrs.size() != 0) $display("[TB] FAIL bp_no_req: got %0d requests expected 0", req_addrs.size()); else passed++;
  endtask

  task automatic test_random(input int n);
    bit ok;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] got;
    spur_en   = 1'b1;
    lat_fixed = 0;
    for (int k = 0; k < n; k++) begin
      wait_valid(ok);
      total++; if (!ok || {pc, instr, pc_plus4, imem_addr} !== {exp_pc, mem_word(exp_pc), exp_pc + 32'd4, exp_pc})
        $display("[TB] FAIL rnd_present%0d: got pc %h instr %h expected pc %h instr %h",
                 k, pc, instr, exp_pc, mem_word(exp_pc)); else passed++;
      for (int s = $urandom_range(0, 3); s > 0; s--) tick();
      src = 2'($urandom_range(0, 3));
      imm = (src == 2'b01 || src == 2'b10) ? (($urandom & 32'h0000_0FFC) - 32'h800) : $urandom;
      req_addrs.delete();
      accept(src, imm);
      exp_pc = ref_next(exp_pc, src, imm);
      got = (req_addrs.size() > 0) ? req_addrs[0] : ~exp_pc;
      total++; if (got !== exp_pc) $display("[TB] FAIL rnd_req%0d: got %h expected %h src %b", k, got, exp_pc, src); else passed++;
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] got;
    wait_valid(ok);
    accept(2'b01, 32'hFFFF_FFFC - exp_pc);
    exp_pc = 32'hFFFF_FFFC;
    wait_valid(ok);
    total++; if (!ok || {pc, pc_plus4} !== {32'hFFFF_FFFC, 32'h0})
      $display("[TB] FAIL wrap_top: got pc %h pc_plus4 %h expected fffffffc 0", pc, pc_plus4); else passed++;
    req_addrs.delete();
    accept(2'b00, $urandom);
    exp_pc = 32'h0;
    got = (req_addrs.size() > 0) ? req_addrs[0] : 32'hFFFF_FFFF;
    total++; if (got !== 32'h0) $display("[TB] FAIL wrap_req: got %h expected 0", got); else passed++;
    wait_valid(ok);
    total++; if (!ok || {pc, instr} !== {32'h0, mem_word(32'h0)})
      $display("[TB] FAIL wrap_present: got pc %h instr %h expected pc 0 instr %h", pc, instr, mem_word(32'h0)); else passed++;
  endtask

  task automatic test_misaligned();
    bit ok;
    wait_valid(ok);
    req_addrs.delete();
    accept(2'b01, 32'h2);
    total++; if ({fetch_err, instr_valid, imem_req} !== 3'b100)
      $display("[TB] FAIL mis_enter: got err %b valid %b req %b expected 1 0 0", fetch_err, instr_valid, imem_req); else passed++;
    for (int i = 0; i < 10; i++) begin
      dec_ready = 1'($urandom);
      tick();
    end
    dec_ready = 1'b0;
    total++; if ({fetch_err, instr_valid} !== 2'b10)
      $display("[TB] FAIL mis_sticky: got err %b valid %b expected 1 0", fetch_err, instr_valid); else passed++;
    total++; if (req_addrs.size() != 0) $display("[TB] FAIL mis_no_req: got %0d requests expected 0", req_addrs.size()); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    mem_auto    = 1'b0;
    spur_en     = 1'b0;
    imem_rvalid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (!seen) $display("[TB] FAIL rmw_first_req: got no request expected one"); else passed++;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total++; if ({pc, instr, instr_valid, fetch_err} !== {RESET_PC, NOP, 1'b0, 1'b0})
      $display("[TB] FAIL rmw_async_reset: got pc %h instr %h v %b err %b expected reset values", pc, instr, instr_valid, fetch_err); else passed++;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if ({imem_req, imem_addr, instr_valid, instr} !== {1'b1, RESET_PC, 1'b0, NOP})
      $display("[TB] FAIL rmw_restart: got req %b addr %h v %b instr %h expected 1 %h 0 %h",
               imem_req, imem_addr, instr_valid, instr, RESET_PC, NOP); else passed++;
    tick();
    imem_rvalid = 1'b0;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(RESET_PC);
    tick();
    imem_rvalid = 1'b0;
    total++; if ({instr_valid, pc, instr} !== {1'b1, RESET_PC, mem_word(RESET_PC)})
      $display("[TB] FAIL rmw_refetch: got v %b pc %h instr %h expected 1 %h %h",
               instr_valid, pc, instr, RESET_PC, mem_word(RESET_PC)); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jal();
    test_backpressure();
    test_random(40);
    test_wrap();
    test_misaligned();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
